// File: rtl/bist_march_sequencer.sv
// March C- BIST sequencer.
// Runs the six-element March C- algorithm over an SRAM of 2**ADDR_W words.
// It issues one read or write per cycle and checks each read one cycle
// after it was issued. It records the first failing address and element,
// and counts miscompares in a saturating counter.
// test_mode drives the normal/test SRAM mux select and follows busy.
`timescale 1ns/1ps

module bist_march_sequencer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              test_mode,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [CNT_W-1:0]  fail_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // M0..M5; M0 and M5 hold one op per address, the others hold two.
    localparam logic [2:0] ELEM_FIRST = 3'd0;
    localparam logic [2:0] ELEM_LAST  = 3'd5;

    state_t            state;
    logic [2:0]        elem;      // march element of the op now on the bus
    logic              phase;     // 0 = first op at this address, 1 = second

    // Op that follows the one currently on the bus
    logic [2:0]        nxt_elem;
    logic              nxt_phase;
    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_we;
    logic              at_end;
    logic              seq_end;
    logic              launch;

    // Compare pipeline: expectation for the read issued last cycle
    logic              cmp_valid;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic [2:0]        cmp_elem;

    // M3 and M4 walk the addresses downward; all other elements walk upward.
    function automatic logic is_desc(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic two_ops(input logic [2:0] e);
        return (e != ELEM_FIRST) && (e != ELEM_LAST);
    endfunction

    // Background written by each element: M0 w0, M1 w1, M2 w0, M3 w1, M4 w0.
    function automatic logic [DATA_W-1:0] write_bg(input logic [2:0] e);
        return {DATA_W{e[0]}};
    endfunction

    // Background read by each element: M1 r0, M2 r1, M3 r0, M4 r1, M5 r0.
    function automatic logic [DATA_W-1:0] read_bg(input logic [2:0] e);
        return {DATA_W{~e[0]}};
    endfunction

    assign launch = start && ((state == S_IDLE) || (state == S_DONE));

    // Work out the next op: finish the address, then step the address, then step the element.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave it unassigned and infer a latch.
        nxt_elem  = elem;
        nxt_phase = phase;
        nxt_addr  = mem_addr;
        seq_end   = 1'b0;
        at_end    = is_desc(elem) ? (mem_addr == '0) : (mem_addr == '1);

        if (two_ops(elem) && !phase) begin
            nxt_phase = 1'b1;
        end else if (!at_end) begin
            nxt_phase = 1'b0;
            nxt_addr  = is_desc(elem) ? mem_addr - 1'b1 : mem_addr + 1'b1;
        end else if (elem == ELEM_LAST) begin
            seq_end = 1'b1;
        end else begin
            nxt_elem  = elem + 3'd1;
            nxt_phase = 1'b0;
            nxt_addr  = is_desc(elem + 3'd1) ? '1 : '0;
        end

        // M0 only writes; in the other two-op elements the second op is the write.
        nxt_we = (nxt_elem == ELEM_FIRST) || nxt_phase;
    end

    // Sequencer FSM; each bus output is registered from the next-op decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is assigned with <= only. All registers then update together at the clock edge.
            state     <= S_IDLE;
            elem      <= ELEM_FIRST;
            phase     <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= '0;
            test_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // First op of M0: write the zero background at address 0
                        state     <= S_RUN;
                        elem      <= ELEM_FIRST;
                        phase     <= 1'b0;
                        mem_addr  <= '0;
                        mem_we    <= 1'b1;
                        mem_re    <= 1'b0;
                        mem_wdata <= write_bg(ELEM_FIRST);
                        test_mode <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (seq_end) begin
                        // Release the bus; the last M5 read is checked during DRAIN
                        state     <= S_DRAIN;
                        elem      <= ELEM_FIRST;
                        phase     <= 1'b0;
                        mem_addr  <= '0;
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b0;
                        mem_wdata <= '0;
                    end else begin
                        elem      <= nxt_elem;
                        phase     <= nxt_phase;
                        mem_addr  <= nxt_addr;
                        mem_we    <= nxt_we;
                        mem_re    <= !nxt_we;
                        mem_wdata <= nxt_we ? write_bg(nxt_elem) : '0;
                    end
                end

                S_DRAIN: begin
                    state     <= S_DONE;
                    test_mode <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture each read's expectation, then check mem_rdata one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid  <= 1'b0;
            cmp_exp    <= '0;
            cmp_addr   <= '0;
            cmp_elem   <= ELEM_FIRST;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= ELEM_FIRST;
            fail_count <= '0;
        end else begin
            cmp_valid <= mem_re;
            if (mem_re) begin
                cmp_exp  <= read_bg(elem);
                cmp_addr <= mem_addr;
                cmp_elem <= elem;
            end

            if (launch) begin
                // A new run starts with clean results. No read is pending in IDLE or DONE.
                fail       <= 1'b0;
                fail_addr  <= '0;
                fail_elem  <= ELEM_FIRST;
                fail_count <= '0;
            end else if (cmp_valid && (mem_rdata != cmp_exp)) begin
                fail <= 1'b1;
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (!fail) begin
                    fail_addr <= cmp_addr;
                    fail_elem <= cmp_elem;
                end
            end
        end
    end

endmodule

// File: tb/tb_bist_march_sequencer.sv
// Testbench for bist_march_sequencer, configured with a 4-word, 8-bit SRAM.
// A scoreboard queue holds the expected bus op for every cycle of a run.
// A behavioural SRAM with an optional stuck-at fault supplies read data.
// A table of fault scenarios holds the expected fail results for each run.
`timescale 1ns/1ps

module tb_bist_march_sequencer;

    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int N    = 1 << AW;
    localparam int NOPS = 10 * N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          test_mode;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [CW-1:0] fail_count;

    bist_march_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .test_mode  (test_mode),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_count (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus op as seen by the SRAM
    typedef struct packed {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    // March C- element description: bit o of is_w/bg describes op o
    typedef struct {
        bit       desc;
        int       nops;
        bit [1:0] is_w;
        bit [1:0] bg;
    } elem_t;

    // Scenario record: injected fault plus expected final fail results
    typedef struct {
        string         name;
        bit            f_en;
        logic [AW-1:0] f_addr;
        logic [DW-1:0] f_mask;
        logic [DW-1:0] f_val;
        logic          x_fail;
        logic [AW-1:0] x_faddr;
        logic [2:0]    x_felem;
        logic [CW-1:0] x_fcount;
    } vec_t;

    elem_t         march [6];
    vec_t          vecs  [4];
    op_t           exp_q [$];

    logic [DW-1:0] mem_model [N];
    bit            pend_valid;
    logic [DW-1:0] pend_data;
    bit            fault_en;
    logic [AW-1:0] fault_addr;
    logic [DW-1:0] fault_mask;
    logic [DW-1:0] fault_val;

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {3'b000, mem_addr, mem_we, mem_re, mem_wdata, test_mode, busy, done,
                fail, fail_addr, fail_elem, fail_count};
    endfunction

    function automatic logic [DW-1:0] sram_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mem_model[a];
        if (fault_en && (a == fault_addr)) v = (v & ~fault_mask) | (fault_val & fault_mask);
        return v;
    endfunction

    // Advance to the next falling edge and act as the SRAM for this cycle.
    // The data for last cycle's read is presented now, so it is stable at the next rising edge.
    task automatic tick();
        @(negedge clk);
        mem_rdata = pend_valid ? pend_data : 8'h5A;
        if (mem_re) begin
            pend_data  = sram_read(mem_addr);
            pend_valid = 1'b1;
        end else begin
            pend_valid = 1'b0;
        end
        if (mem_we) mem_model[mem_addr] = mem_wdata;
    endtask

    // Expand the march table into the 10N-op bus sequence
    task automatic push_ops();
        op_t o;
        for (int e = 0; e < 6; e++) begin
            for (int s = 0; s < N; s++) begin
                for (int k = 0; k < march[e].nops; k++) begin
                    o.we    = march[e].is_w[k];
                    o.re    = !march[e].is_w[k];
                    o.addr  = AW'(march[e].desc ? (N - 1 - s) : s);
                    o.wdata = march[e].is_w[k] ? {DW{march[e].bg[k]}} : '0;
                    exp_q.push_back(o);
                end
            end
        end
    endtask

    // Start a run at the current falling edge and follow it cycle by cycle up to DONE.
    // pa/pb are cycles in which start is pulsed again. rst_at is the cycle in which reset is forced.
    task automatic run_seq(input int pa, input int pb, input int rst_at);
        op_t e;
        op_t obs;
        bit  b;
        start = 1'b1;
        push_ops();
        for (int i = 1; i <= NOPS + 2; i++) begin
            tick();
            obs = {mem_we, mem_re, mem_addr, mem_wdata};
            if (i == 1)
                check("clear_on_start", 32'({done, fail, fail_addr, fail_elem, fail_count}), 32'(0));
            if (i <= NOPS) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("op%0d", i - 1), 32'(obs), 32'(e));
                end
            end else begin
                check($sformatf("bus_idle_c%0d", i), 32'({mem_we, mem_re, mem_wdata}), 32'(0));
            end
            b = (i <= NOPS + 1);
            check($sformatf("status_c%0d", i), 32'({test_mode, busy, done}), 32'({b, b, !b}));
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("async_reset", all_outs(), 32'(0));
                exp_q.delete();
                pend_valid = 1'b0;
                start      = 1'b0;
                return;
            end
            start = (i == pa) || (i == pb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        mem_rdata  = '0;
        pend_valid = 1'b0;
        pend_data  = '0;
        fault_en   = 1'b0;
        fault_addr = '0;
        fault_mask = '0;
        fault_val  = '0;
        for (int a = 0; a < N; a++) mem_model[a] = '0;

        //           desc  nops  is_w   bg
        march[0] = '{1'b0, 1, 2'b01, 2'b00};  // M0 up   w0
        march[1] = '{1'b0, 2, 2'b10, 2'b10};  // M1 up   r0 w1
        march[2] = '{1'b0, 2, 2'b10, 2'b01};  // M2 up   r1 w0
        march[3] = '{1'b1, 2, 2'b10, 2'b10};  // M3 down r0 w1
        march[4] = '{1'b1, 2, 2'b10, 2'b01};  // M4 down r1 w0
        march[5] = '{1'b0, 1, 2'b00, 2'b00};  // M5 up   r0

        //          name        en    addr   mask   val    fail  faddr  felem  fcount
        vecs[0] = '{"clean",    1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 3'd0, 8'd0};
        vecs[1] = '{"a2b0_sa1", 1'b1, 2'd2, 8'h01, 8'h01, 1'b1, 2'd2, 3'd1, 8'd3};
        vecs[2] = '{"a0_sa0",   1'b1, 2'd0, 8'hFF, 8'h00, 1'b1, 2'd0, 3'd2, 8'd2};
        vecs[3] = '{"reclean",  1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 3'd0, 8'd0};

        repeat (2) tick();
        check("reset_outputs", all_outs(), 32'(0));
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_outputs", all_outs(), 32'(0));

        // Full runs under each fault scenario; each run after the first starts from DONE
        for (int v = 0; v < 4; v++) begin
            fault_en   = vecs[v].f_en;
            fault_addr = vecs[v].f_addr;
            fault_mask = vecs[v].f_mask;
            fault_val  = vecs[v].f_val;
            run_seq(0, 0, 0);
            check({vecs[v].name, "_fail"},   32'(fail),       32'(vecs[v].x_fail));
            check({vecs[v].name, "_faddr"},  32'(fail_addr),  32'(vecs[v].x_faddr));
            check({vecs[v].name, "_felem"},  32'(fail_elem),  32'(vecs[v].x_felem));
            check({vecs[v].name, "_fcount"}, 32'(fail_count), 32'(vecs[v].x_fcount));
        end

        // Extra start pulses at op 5 and in DRAIN must not disturb the run
        fault_en = 1'b0;
        run_seq(6, NOPS + 1, 0);
        check("restart_ignored_fail", 32'({fail, fail_count}), 32'(0));
        tick();
        check("restart_ignored_done", 32'({busy, done}), 32'(2'b01));

        // Reset during op 15, then a full clean run
        run_seq(0, 0, 16);
        tick();
        check("reset_held", all_outs(), 32'(0));
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", all_outs(), 32'(0));
        run_seq(0, 0, 0);
        check("post_reset_fail", 32'({fail, fail_count}), 32'(0));
        check("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
